tt_sweep_checker: RTL

Sequential characterization block for the 3-input logic-gate library. It drives all eight input combinations of a combinational gate under test (DUT), samples the gate output after a programmable settle time, and assembles the gate's 8-bit truth-table code, for example 0xD2. It then compares that code against an expected value. It is the read-back counterpart of the truth-table gate modules: a gate maps a code to behaviour, and this block maps behaviour back to a code. It sits in the library self-test harness.

---
 rtl/tt_sweep_checker.sv | 126 ++++++++++++
 1 files changed

// File: rtl/tt_sweep_checker.sv
// Truth-table sweep checker: walks a 3-input gate through all eight vectors,
// samples its synchronized output and rebuilds the 8-bit truth-table code.
module tt_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    output logic [2:0] dut_in,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt_code,
    output logic       match
);
    // state  | meaning
    // S_IDLE | waiting for start, outputs hold last result
    // S_RUN  | applying vectors 0..7, each for SETTLE_CYCLES cycles
    // S_DONE | one-cycle completion pulse, result visible
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_bad_cfg
            $error("tt_sweep_checker: SETTLE_CYCLES must be within 3..255");
        end
    endgenerate

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] tt_code_q, tt_code_d;
    logic       match_q, match_d;
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       dut_out_s;
    logic [7:0] shreg_smp;

    assign dut_out_s = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            cnt_q     <= 8'd0;
            shreg_q   <= 8'd0;
            exp_q     <= 8'd0;
            tt_code_q <= 8'd0;
            match_q   <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            exp_q     <= exp_d;
            tt_code_q <= tt_code_d;
            match_q   <= match_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        exp_d     = exp_q;
        tt_code_d = tt_code_q;
        match_d   = match_q;
        sync1_d   = dut_out;
        sync2_d   = sync1_q;
        // Vector 000 lands in the MSB, vector 111 in the LSB.
        shreg_smp = shreg_q;
        shreg_smp[3'd7 - idx_q] = dut_out_s;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                    shreg_d = 8'd0;
                    exp_d   = expected;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d   = 8'd0;
                    shreg_d = shreg_smp;
                    if (idx_q == 3'd7) begin
                        // Result registered on entry so it is visible alongside done.
                        state_d   = S_DONE;
                        tt_code_d = shreg_smp;
                        match_d   = (shreg_smp == exp_q);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        dut_in  = idx_q;
        tt_code = tt_code_q;
        match   = match_q;
    end

endmodule
